// File: rtl/line_motion_ctrl_pkg.sv
//------------------------------------------------------------------------------
// line_motion_ctrl_pkg
// Shared encodings and screen geometry for the line head and the renderer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package line_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    DIR_EAST  = 1'b0,
    DIR_NORTH = 1'b1
  } dir_t;

  localparam logic [15:0] c_START_X   = 16'd336;
  localparam logic [15:0] c_START_Y   = 16'd240;
  localparam logic [15:0] c_SCREEN_CX = 16'd320;
  localparam logic [15:0] c_SCREEN_CY = 16'd240;

  // Scroll origin that places world coordinate pos at screen coordinate ctr.
  function automatic logic [15:0] scroll_of(input logic [15:0] pos, input logic [15:0] ctr);
    return pos - ctr + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_motion_ctrl_progress_counter.sv
//------------------------------------------------------------------------------
// line_motion_ctrl_progress_counter
// Per-mille progress from movement steps, saturating, with a reach-max flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_motion_ctrl_progress_counter #(
  parameter int STEPS_PER_PM = 4,
  parameter int PROG_MAX     = 1000
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic       i_step,
  output logic [9:0] o_progress,
  output logic       o_done_nxt
);

  localparam int                 c_CNT_W    = (STEPS_PER_PM > 1) ? $clog2(STEPS_PER_PM) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEPS_PER_PM - 1);
  localparam logic [9:0]         c_PROG_MAX = 10'(PROG_MAX);

  logic [c_CNT_W-1:0] r_step_cnt;
  logic [9:0]         r_progress;
  logic               w_wrap;

  assign w_wrap     = i_step && (r_step_cnt == c_CNT_LAST);
  // Combinational so the owner can leave RUN on the same edge progress hits max.
  assign o_done_nxt = w_wrap && (r_progress == c_PROG_MAX - 10'd1);
  assign o_progress = r_progress;

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      r_step_cnt <= '0;
      r_progress <= '0;
    end else if (i_step) begin
      if (w_wrap) begin
        r_step_cnt <= '0;
        if (r_progress != c_PROG_MAX) begin
          r_progress <= r_progress + 10'd1;
        end
      end else begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_motion_ctrl.sv
//------------------------------------------------------------------------------
// line_motion_ctrl
// Line-head motion FSM: head position, scroll, corner press, progress, tips.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_motion_ctrl
  import line_motion_ctrl_pkg::*;
#(
  parameter logic [15:0] START_X      = c_START_X,
  parameter logic [15:0] START_Y      = c_START_Y,
  parameter logic [15:0] SCREEN_CX    = c_SCREEN_CX,
  parameter logic [15:0] SCREEN_CY    = c_SCREEN_CY,
  parameter logic [15:0] STEP         = 16'd2,
  parameter int          STEPS_PER_PM = 4,
  parameter int          PROG_MAX     = 1000
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn,
  input  logic        collide,
  output logic [15:0] head_x,
  output logic [15:0] head_y,
  output logic [15:0] scroll_x_out,
  output logic [15:0] scroll_y_out,
  output logic        press,
  output logic [9:0]  progress,
  output logic        tips_display,
  output logic        tips_display_over,
  output logic        running
);

  state_t      r_state;
  dir_t        r_dir;
  logic        r_btn_q;
  logic        r_turn_pend;
  logic [15:0] r_head_x;
  logic [15:0] r_head_y;
  logic [15:0] r_scroll_x;
  logic [15:0] r_scroll_y;
  logic        r_press;
  logic        r_tips;
  logic        r_tips_over;
  logic        r_running;

  logic        w_edge;
  logic        w_run_tick;
  logic        w_die;
  logic        w_turn;
  logic        w_move;
  logic        w_done_nxt;
  logic [15:0] w_head_x_nxt;
  logic [15:0] w_head_y_nxt;

  // Only turns latched before this cycle are served; a same-cycle edge waits.
  always_comb begin
    w_edge       = btn & ~r_btn_q;
    w_run_tick   = (r_state == ST_RUN) && tick;
    w_die        = w_run_tick && collide;
    w_turn       = w_run_tick && !collide && r_turn_pend;
    w_move       = w_run_tick && !collide && !r_turn_pend;
    w_head_x_nxt = r_head_x;
    w_head_y_nxt = r_head_y;
    if (w_move) begin
      if (r_dir == DIR_EAST) begin
        w_head_x_nxt = r_head_x + STEP;
      end else begin
        w_head_y_nxt = r_head_y - STEP;
      end
    end
  end

  line_motion_ctrl_progress_counter #(
    .STEPS_PER_PM (STEPS_PER_PM),
    .PROG_MAX     (PROG_MAX)
  ) u_progress (
    .hclk       (hclk),
    .reset      (reset),
    .i_step     (w_move),
    .o_progress (progress),
    .o_done_nxt (w_done_nxt)
  );

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_EAST;
      r_btn_q     <= 1'b0;
      r_turn_pend <= 1'b0;
      r_head_x    <= START_X;
      r_head_y    <= START_Y;
      r_scroll_x  <= scroll_of(START_X, SCREEN_CX);
      r_scroll_y  <= scroll_of(START_Y, SCREEN_CY);
      r_press     <= 1'b0;
      r_tips      <= 1'b1;
      r_tips_over <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_btn_q    <= btn;
      r_press    <= w_turn;
      r_head_x   <= w_head_x_nxt;
      r_head_y   <= w_head_y_nxt;
      r_scroll_x <= scroll_of(w_head_x_nxt, SCREEN_CX);
      r_scroll_y <= scroll_of(w_head_y_nxt, SCREEN_CY);
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state   <= ST_RUN;
            r_tips    <= 1'b0;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_turn) begin
            r_dir       <= dir_t'(~r_dir);
            r_turn_pend <= w_edge;
          end else if (w_edge) begin
            r_turn_pend <= 1'b1;
          end
          if (w_die) begin
            r_state     <= ST_DEAD;
            r_running   <= 1'b0;
            r_tips_over <= 1'b1;
          end else if (w_done_nxt) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_x            = r_head_x;
  assign head_y            = r_head_y;
  assign scroll_x_out      = r_scroll_x;
  assign scroll_y_out      = r_scroll_y;
  assign press             = r_press;
  assign tips_display      = r_tips;
  assign tips_display_over = r_tips_over;
  assign running           = r_running;

endmodule

`default_nettype wire

// File: tb/tb_line_motion_ctrl.sv
//------------------------------------------------------------------------------
// tb_line_motion_ctrl
// Randomized and directed bench against a behavioural line-head model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_motion_ctrl;

  logic        hclk    = 1'b0;
  logic        reset   = 1'b1;
  logic        tick    = 1'b0;
  logic        btn     = 1'b0;
  logic        collide = 1'b0;
  logic [15:0] head_x, head_y, scroll_x_out, scroll_y_out;
  logic        press, tips_display, tips_display_over, running;
  logic [9:0]  progress;

  line_motion_ctrl dut (
    .hclk              (hclk),
    .reset             (reset),
    .tick              (tick),
    .btn               (btn),
    .collide           (collide),
    .head_x            (head_x),
    .head_y            (head_y),
    .scroll_x_out      (scroll_x_out),
    .scroll_y_out      (scroll_y_out),
    .press             (press),
    .progress          (progress),
    .tips_display      (tips_display),
    .tips_display_over (tips_display_over),
    .running           (running)
  );

  always #5 hclk = ~hclk;

  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt = 0;

  // Model: 0 idle, 1 run, 2 dead, 3 done
  int          m_st;
  logic [15:0] m_x, m_y;
  bit          m_north, m_pend, m_press, m_prevb;
  int          m_moves;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 16'd336; m_y = 16'd240;
    m_north = 0; m_pend = 0; m_press = 0; m_prevb = 0; m_moves = 0;
  endtask

  task automatic model_step(input bit t, input bit b, input bit c);
    bit e;
    e = b && !m_prevb;
    m_prevb = b;
    m_press = 0;
    if (m_st == 0) begin
      if (e) m_st = 1;
    end else if (m_st == 1) begin
      if (t && c) begin
        m_st = 2;
      end else if (t && m_pend) begin
        m_press = 1;
        m_north = !m_north;
        m_pend = e;
      end else if (t) begin
        if (m_north) m_y = m_y - 16'd2;
        else         m_x = m_x + 16'd2;
        m_moves++;
        if (m_moves == 4000) m_st = 3;
        if (e) m_pend = 1;
      end else if (e) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic compare_all();
    int exp_prog;
    exp_prog = (m_moves / 4 > 1000) ? 1000 : m_moves / 4;
    chk("head_x", 32'(head_x), 32'(m_x));
    chk("head_y", 32'(head_y), 32'(m_y));
    chk("scroll_x", 32'(scroll_x_out), 32'(16'(m_x - 16'd320 + 16'd1)));
    chk("scroll_y", 32'(scroll_y_out), 32'(16'(m_y - 16'd240 + 16'd1)));
    chk("press", 32'(press), 32'(m_press));
    chk("progress", 32'(progress), 32'(exp_prog));
    chk("tips_display", 32'(tips_display), 32'(m_st == 0));
    chk("tips_display_over", 32'(tips_display_over), 32'(m_st == 2));
    chk("running", 32'(running), 32'(m_st == 1));
    if (press === 1'b1) press_cnt++;
  endtask

  task automatic cycle(input bit t, input bit b, input bit c);
    @(negedge hclk);
    tick = t; btn = b; collide = c;
    model_step(t, b, c);
    @(posedge hclk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge hclk);
    reset = 1; tick = 0; btn = 0; collide = 0;
    model_reset();
    @(posedge hclk);
    #1;
    compare_all();
    @(negedge hclk);
    reset = 0;
  endtask

  initial begin
    int pc0;
    bit t, b, c;
    model_reset();

    // Idle: ticks without a button do nothing
    do_reset();
    repeat (5) cycle(1, 0, 0);
    chk("lit_idle_x", 32'(head_x), 32'd336);
    chk("lit_idle_sx", 32'(scroll_x_out), 32'd17);
    chk("lit_idle_sy", 32'(scroll_y_out), 32'd1);
    chk("lit_idle_tips", 32'(tips_display), 32'd1);

    // Start, three moves east
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    chk("lit_run_x", 32'(head_x), 32'd342);
    chk("lit_run_sx", 32'(scroll_x_out), 32'd23);
    chk("lit_no_press", 32'(press_cnt), 32'd0);
    chk("lit_running", 32'(running), 32'd1);

    // Corner commit holds head, then north move wraps scroll_y
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("lit_press", 32'(press), 32'd1);
    chk("lit_corner_x", 32'(head_x), 32'd342);
    chk("lit_corner_y", 32'(head_y), 32'd240);
    cycle(1, 0, 0);
    chk("lit_north_y", 32'(head_y), 32'd238);
    chk("lit_wrap_sy", 32'(scroll_y_out), 32'd65535);

    // Three edges between ticks collapse to a single turn
    repeat (3) begin
      cycle(0, 1, 0);
      cycle(0, 0, 0);
    end
    pc0 = press_cnt;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("lit_one_press", 32'(press_cnt - pc0), 32'd1);
    chk("lit_east_again", 32'(head_x), 32'd344);

    // Edge with a tick is served on the following tick
    cycle(1, 1, 0);
    chk("lit_coinc_nopress", 32'(press), 32'd0);
    chk("lit_coinc_x", 32'(head_x), 32'd346);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("lit_coinc_press", 32'(press), 32'd1);

    // Collision beats a pending turn; head then frozen
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 1);
    chk("lit_dead_nopress", 32'(press), 32'd0);
    chk("lit_dead_over", 32'(tips_display_over), 32'd1);
    repeat (3) cycle(1, 0, 0);
    chk("lit_dead_x", 32'(head_x), 32'd346);
    chk("lit_dead_y", 32'(head_y), 32'd238);

    // Asynchronous reset in the middle of a run
    do_reset();
    cycle(0, 1, 0);
    repeat (10) cycle(1, 0, 0);
    reset = 1;
    model_reset();
    #2;
    compare_all();
    chk("lit_areset_x", 32'(head_x), 32'd336);
    chk("lit_areset_tips", 32'(tips_display), 32'd1);
    @(negedge hclk);
    reset = 0;

    // Randomized play
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int i = 0; i < 800; i++) begin
        t = ($urandom_range(0, 2) == 0);
        b = ($urandom_range(0, 4) == 0) ? !btn : btn;
        c = t && ($urandom_range(0, 299) == 0);
        cycle(t, b, c);
      end
    end

    // Full level to completion
    do_reset();
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    repeat (7) cycle(1, 0, 0);
    chk("lit_prog_1", 32'(progress), 32'd1);
    repeat (3993) cycle(1, 0, 0);
    chk("lit_prog_max", 32'(progress), 32'd1000);
    chk("lit_done_run", 32'(running), 32'd0);
    chk("lit_done_x", 32'(head_x), 32'd8336);
    repeat (5) cycle(1, 0, 0);
    chk("lit_done_hold_p", 32'(progress), 32'd1000);
    chk("lit_done_hold_x", 32'(head_x), 32'd8336);
    chk("lit_done_tips", 32'(tips_display), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
